// File: rtl/fpu_sched.sv
// Round-robin sequencer sharing one combinational half-precision adder between two
// requesters: latch operands, wait FPU_LAT cycles, capture the sum, return it to the owner.
module fpu_sched #(
   parameter int FPU_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [15:0] req0_a,
   input  logic [15:0] req0_b,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [15:0] rsp0_r,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [15:0] req1_a,
   input  logic [15:0] req1_b,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [15:0] rsp1_r,
   output logic [15:0] fpu_a,
   output logic [15:0] fpu_b,
   input  logic [15:0] fpu_r,
   output logic        busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;
   localparam logic [3:0] LAT_INIT = 4'(FPU_LAT);

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic        owner;
   logic        last_grant;
   logic        grant;
   logic        accept;
   logic        rsp_take;
   logic [15:0] result;

   // On a tie the requester that did not win last time gets the adder.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid)
         grant = ~last_grant;
      else if (req1_valid)
         grant = 1'b1;
   end

   // Ready is gated by rst_n so it drops at once when reset is asserted.
   assign req0_ready = rst_n & (state == IDLE) & req0_valid & ~grant;
   assign req1_ready = rst_n & (state == IDLE) & req1_valid & grant;
   assign accept     = req0_ready | req1_ready;
   assign rsp_take   = owner ? rsp1_ready : rsp0_ready;

   assign rsp0_valid = (state == RESP) & ~owner;
   assign rsp1_valid = (state == RESP) & owner;
   assign rsp0_r     = result;
   assign rsp1_r     = result;
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         fpu_a      <= 16'd0;
         fpu_b      <= 16'd0;
         result     <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  fpu_a      <= grant ? req1_a : req0_a;
                  fpu_b      <= grant ? req1_b : req0_b;
                  owner      <= grant;
                  last_grant <= grant;
                  cnt        <= LAT_INIT;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               cnt <= cnt - 4'd1;
               // cnt<=1 rather than ==1 so an out-of-range count cannot stall here.
               if (cnt <= 4'd1) begin
                  result <= fpu_r;
                  state  <= RESP;
               end
            end
            RESP: begin
               if (rsp_take)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_sched.sv
// Bench for fpu_sched: directed and randomized traffic on an FPU_LAT=1 instance against a
// transaction-level model, plus latency and async-reset checks on an FPU_LAT=4 instance.
module tb_fpu_sched;

   localparam int LAT1 = 1;
   localparam int LAT4 = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   // FPU_LAT=1 instance
   logic        v0 = 0, v1 = 0, rr0 = 0, rr1 = 0;
   logic [15:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
   logic        rdy0, rdy1, rsv0, rsv1, bsy;
   logic [15:0] rsr0, rsr1, fa, fb, fr;

   // FPU_LAT=4 instance
   logic        l4_v0 = 0, l4_v1 = 0, l4_rr0 = 0, l4_rr1 = 0;
   logic [15:0] l4_a0 = 0, l4_b0 = 0, l4_a1 = 0, l4_b1 = 0;
   logic        l4_rdy0, l4_rdy1, l4_rsv0, l4_rsv1, l4_bsy;
   logic [15:0] l4_rsr0, l4_rsr1, l4_fa, l4_fb, l4_fr;

   int n_checks = 0;
   int n_errors = 0;

   // Stand-in for the adder: known half-precision sums for the directed cases, a
   // scrambled but deterministic value otherwise.
   function automatic logic [15:0] fpu_fn(input logic [15:0] a, input logic [15:0] b);
      if (a == 16'hCA60 && b == 16'hC460) return 16'hCC48;
      if (a == 16'h4400 && b == 16'hC400) return 16'h0000;
      return (a + b) ^ 16'h5A5A;
   endfunction

   assign fr    = fpu_fn(fa, fb);
   assign l4_fr = fpu_fn(l4_fa, l4_fb);

   fpu_sched #(.FPU_LAT(LAT1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req0_ready(rdy0), .req0_a(a0), .req0_b(b0),
      .rsp0_valid(rsv0), .rsp0_ready(rr0), .rsp0_r(rsr0),
      .req1_valid(v1), .req1_ready(rdy1), .req1_a(a1), .req1_b(b1),
      .rsp1_valid(rsv1), .rsp1_ready(rr1), .rsp1_r(rsr1),
      .fpu_a(fa), .fpu_b(fb), .fpu_r(fr), .busy(bsy)
   );

   fpu_sched #(.FPU_LAT(LAT4)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(l4_v0), .req0_ready(l4_rdy0), .req0_a(l4_a0), .req0_b(l4_b0),
      .rsp0_valid(l4_rsv0), .rsp0_ready(l4_rr0), .rsp0_r(l4_rsr0),
      .req1_valid(l4_v1), .req1_ready(l4_rdy1), .req1_a(l4_a1), .req1_b(l4_b1),
      .rsp1_valid(l4_rsv1), .rsp1_ready(l4_rr1), .rsp1_r(l4_rsr1),
      .fpu_a(l4_fa), .fpu_b(l4_fb), .fpu_r(l4_fr), .busy(l4_bsy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Transaction model: one operation in flight, waiting m_wait more edges for its sum.
   bit          m_busy, m_owner, m_last, acc0, acc1;
   int          m_wait;
   logic [15:0] m_res, m_rout, m_a, m_b;

   task automatic m_reset();
      m_busy = 0; m_owner = 0; m_last = 1; m_wait = 0;
      m_res = 0; m_rout = 0; m_a = 0; m_b = 0; acc0 = 0; acc1 = 0;
   endtask

   // Called at a negedge with inputs already applied; checks outputs, then models the edge.
   task automatic step();
      bit g, e_r0, e_r1, e_v0, e_v1;
      #1;
      g    = (v0 && v1) ? !m_last : v1;
      e_r0 = !m_busy && v0 && !g;
      e_r1 = !m_busy && v1 && g;
      e_v0 = m_busy && m_wait == 0 && !m_owner;
      e_v1 = m_busy && m_wait == 0 && m_owner;
      chk("req0_ready", 32'(rdy0), 32'(e_r0));
      chk("req1_ready", 32'(rdy1), 32'(e_r1));
      chk("rsp0_valid", 32'(rsv0), 32'(e_v0));
      chk("rsp1_valid", 32'(rsv1), 32'(e_v1));
      chk("rsp0_r", 32'(rsr0), 32'(m_rout));
      chk("rsp1_r", 32'(rsr1), 32'(m_rout));
      chk("busy", 32'(bsy), 32'(m_busy));
      chk("fpu_a", 32'(fa), 32'(m_a));
      chk("fpu_b", 32'(fb), 32'(m_b));
      @(posedge clk);
      acc0 = 0; acc1 = 0;
      if (!m_busy) begin
         if (e_r0 || e_r1) begin
            m_busy = 1; m_owner = g; m_last = g; m_wait = LAT1;
            m_a = g ? a1 : a0; m_b = g ? b1 : b0;
            m_res = fpu_fn(m_a, m_b);
            acc0 = e_r0; acc1 = e_r1;
         end
      end else if (m_wait > 0) begin
         m_wait--;
         if (m_wait == 0) m_rout = m_res;
      end else if (m_owner ? rr1 : rr0) begin
         m_busy = 0;
      end
      @(negedge clk);
   endtask

   initial begin
      logic [15:0] ra, rb, hold_r;
      m_reset();
      #2 rst_n = 1'b0;
      v0 = 1; v1 = 1;
      #1;
      chk("rst_req0_ready", 32'(rdy0), 0);
      chk("rst_req1_ready", 32'(rdy1), 0);
      chk("rst_busy", 32'(bsy), 0);
      chk("rst_rsp_valid", 32'({rsv0, rsv1}), 0);
      chk("rst_rsp_r", 32'({rsr0, rsr1}), 0);
      chk("rst_fpu_ab", 32'({fa, fb}), 0);
      @(negedge clk);
      rst_n = 1'b1; v0 = 0; v1 = 0;
      step();

      // Single operation from requester 0
      v0 = 1; a0 = 16'hCA60; b0 = 16'hC460; rr0 = 1;
      #1 chk("single_ready0", 32'(rdy0), 1);
      step();
      v0 = 0;
      chk("single_rsp0_valid", 32'(rsv0), 0);
      step();
      chk("single_rsp0_valid_after", 32'(rsv0), 1);
      chk("single_rsp0_r", 32'(rsr0), 32'h0000CC48);
      chk("single_rsp1_valid", 32'(rsv1), 0);
      step();

      // Cancellation on requester 1
      v1 = 1; a1 = 16'h4400; b1 = 16'hC400; rr1 = 1;
      step();
      v1 = 0;
      step();
      chk("cancel_rsp1_valid", 32'(rsv1), 1);
      chk("cancel_rsp1_r", 32'(rsr1), 32'h0);
      chk("cancel_rsp0_valid", 32'(rsv0), 0);
      step();

      // Ties alternate 0,1,0,1 (last grant was requester 1)
      v0 = 1; v1 = 1; a0 = 16'h1111; b0 = 16'h2222; a1 = 16'h3333; b1 = 16'h4444;
      for (int i = 0; i < 4; i++) begin
         #1 chk("tie_grant1", 32'(rdy1), 32'(i % 2));
         step();
         if (acc0) begin a0 = 16'($urandom); b0 = 16'($urandom); end
         if (acc1) begin a1 = 16'($urandom); b1 = 16'($urandom); end
         step();
         step();
      end
      v0 = 0; v1 = 0;
      step();

      // Backpressure on requester 0 while requester 1 waits
      v0 = 1; v1 = 1; rr0 = 0; rr1 = 1; a0 = 16'hABCD; b0 = 16'h1234;
      step();
      v0 = 0;
      step();
      hold_r = rsr0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp0_valid", 32'(rsv0), 1);
         chk("bp_rsp0_r", 32'(rsr0), 32'(hold_r));
         chk("bp_busy", 32'(bsy), 1);
         chk("bp_req1_ready", 32'(rdy1), 0);
         step();
      end
      rr0 = 1;
      step();
      chk("bp_release_idle", 32'(bsy), 0);
      step();
      v1 = 0;
      for (int i = 0; i < 3; i++) step();

      // Randomized traffic under the valid/ready hold rule
      for (int c = 0; c < 400; c++) begin
         rr0 = 1'($urandom_range(0, 3) != 0);
         rr1 = 1'($urandom_range(0, 3) != 0);
         if (!v0 || acc0) begin
            v0 = 1'($urandom_range(0, 1)); a0 = 16'($urandom); b0 = 16'($urandom);
         end
         if (!v1 || acc1) begin
            v1 = 1'($urandom_range(0, 1)); a1 = 16'($urandom); b1 = 16'($urandom);
         end
         step();
      end
      v0 = 0; v1 = 0; rr0 = 1; rr1 = 1;
      for (int i = 0; i < 5; i++) step();

      // FPU_LAT=4 latency and operand stability
      ra = 16'h3C00; rb = 16'h4000;
      l4_v0 = 1; l4_a0 = ra; l4_b0 = rb; l4_rr0 = 0;
      #1 chk("l4_ready0", 32'(l4_rdy0), 1);
      @(posedge clk);
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         l4_v0 = 0;
         chk("l4_rsp0_valid", 32'(l4_rsv0), 32'(k == 4));
         chk("l4_fpu_a", 32'(l4_fa), 32'(ra));
         chk("l4_fpu_b", 32'(l4_fb), 32'(rb));
         chk("l4_busy", 32'(l4_bsy), 1);
         if (k < 4) @(posedge clk);
      end
      chk("l4_rsp0_r", 32'(l4_rsr0), 32'(fpu_fn(ra, rb)));
      chk("l4_rsp1_valid", 32'(l4_rsv1), 0);
      l4_rr0 = 1;
      @(negedge clk);
      chk("l4_back_idle", 32'(l4_bsy), 0);

      // Reset asserted mid-EXEC
      l4_v0 = 1; l4_a0 = 16'h5555; l4_b0 = 16'h6666;
      @(posedge clk);
      @(negedge clk);
      l4_v0 = 0;
      @(posedge clk);
      #3;
      chk("mid_exec_busy_before", 32'(l4_bsy), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(l4_bsy), 0);
      chk("mid_rst_rsp_valid", 32'({l4_rsv0, l4_rsv1}), 0);
      chk("mid_rst_fpu_a", 32'(l4_fa), 0);
      chk("mid_rst_fpu_b", 32'(l4_fb), 0);
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
      l4_v0 = 1; l4_v1 = 1;
      #1;
      chk("post_rst_tie_l4_0", 32'(l4_rdy0), 1);
      chk("post_rst_tie_l4_1", 32'(l4_rdy1), 0);
      l4_v0 = 0; l4_v1 = 0;
      v0 = 1; v1 = 1;
      #1 chk("post_rst_tie_0", 32'(rdy0), 1);
      step();
      v0 = 0;
      for (int i = 0; i < 3; i++) step();
      v1 = 0;
      for (int i = 0; i < 3; i++) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
